// File: rtl/vram_write_buffer_pkg.sv
// Shared definitions for the CPU-to-VRAM write buffer: entry layout and
// width helpers used by the top level and its FIFO.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

package vram_write_buffer_pkg;

    localparam int DATA_W        = 8;
    localparam int VRAM_ADDR_W   = `VRAM_ADDR_WIDTH;
    localparam int DEFAULT_DEPTH = 16;

    // One queued CPU write at the default VRAM address width.
    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      data;
    } vram_entry_t;

    // Packed entry width for a given address width: {addr, data}.
    function automatic int entry_width(input int addr_w);
        return addr_w + DATA_W;
    endfunction

endpackage

// File: rtl/vram_write_buffer_if.sv
// CPU write bus into the VRAM write buffer. The CPU side is the master
// (drives strobe/address/data), the buffer is the slave (returns ready).
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

interface vram_write_buffer_if
    import vram_write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH
) ();

    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [DATA_W-1:0]     cpu_data;
    logic                  cpu_ready;

    modport master (
        output cpu_we,
        output cpu_address,
        output cpu_data,
        input  cpu_ready
    );

    modport slave (
        input  cpu_we,
        input  cpu_address,
        input  cpu_data,
        output cpu_ready
    );

endinterface

// File: rtl/vram_write_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always
// visible on rd_data; push/pop are qualified internally by full/empty so a
// push while full (even with a simultaneous pop) is refused.
module sync_fifo_m #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    // Status decodes from the registered level only.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents are intentionally not reset, writes blocked in reset.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_buffer.sv
// CPU write buffer in front of the GPU VRAM port. CPU writes are queued at
// any time and drained one per clock only while the video timing reports
// the writable window, so they never collide with scan-out fetches.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module vram_write_buffer
    import vram_write_buffer_pkg::*;
#(
    parameter  int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int LVL_W      = $clog2(DEPTH) + 1,
    localparam int ENTRY_W    = entry_width(ADDR_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    vram_write_buffer_if.slave     bus,
    input  logic                   writable,
    output logic                   vram_we,
    output logic [ADDR_WIDTH-1:0]  vram_address,
    output logic [DATA_W-1:0]      vram_data,
    output logic [LVL_W-1:0]       level,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_W-1:0]     data;
    } entry_t;

    entry_t             wr_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] head_bits;
    logic               full;
    logic               push;
    logic               drop;

    assign wr_entry      = '{addr: bus.cpu_address, data: bus.cpu_data};
    assign bus.cpu_ready = !full;
    assign push          = bus.cpu_we && !full;
    assign drop          = bus.cpu_we && full;

    // No bypass: an entry pushed this cycle is not at the head until next cycle.
    assign vram_we       = writable && !empty;
    assign head          = entry_t'(head_bits);
    assign vram_address  = head.addr;
    assign vram_data     = head.data;

    sync_fifo_m #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (vram_we),
        .wr_data (wr_entry),
        .rd_data (head_bits),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_buffer.sv
// Self-checking bench for vram_write_buffer: a table of single-cycle
// vectors for basic ordering/latency, then directed multi-cycle sequences
// and a queue-based run that wraps the pointers several times.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module tb_vram_write_buffer;

    localparam int AW    = `VRAM_ADDR_WIDTH;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          writable = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          vram_we;
    logic [AW-1:0] vram_address;
    logic [7:0]    vram_data;
    logic [4:0]    level;
    logic          empty;
    logic          overflow;

    vram_write_buffer_if #(.ADDR_WIDTH(AW)) bus ();

    vram_write_buffer #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .writable     (writable),
        .vram_we      (vram_we),
        .vram_address (vram_address),
        .vram_data    (vram_data),
        .level        (level),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          wr;
        logic          e_vwe;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_data;
        logic          e_ready;
        logic [4:0]    e_level;
        logic          e_ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_we      = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_data    = '0;
        writable        = 1'b0;
        overflow_clr    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic push_n(input int n, input logic [AW-1:0] base_a, input logic [7:0] base_d);
        for (int i = 0; i < n; i++) begin
            bus.cpu_we      = 1'b1;
            bus.cpu_address = base_a + AW'(i);
            bus.cpu_data    = base_d + 8'(i);
            tick();
        end
        bus.cpu_we = 1'b0;
    endtask

    task automatic drain_check(input string tag, input int n, input logic [AW-1:0] base_a,
                               input logic [7:0] base_d);
        writable = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("%s vram_we[%0d]", tag, i), 32'(vram_we), 32'd1);
            chk($sformatf("%s addr[%0d]", tag, i), 32'(vram_address), 32'(base_a + AW'(i)));
            chk($sformatf("%s data[%0d]", tag, i), 32'(vram_data), 32'(base_d + 8'(i)));
            tick();
        end
        #1;
        chk($sformatf("%s empty after drain", tag), 32'(empty), 32'd1);
        chk($sformatf("%s no write when empty", tag), 32'(vram_we), 32'd0);
        writable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            nwr;
        logic [AW+7:0] q [$];
        logic          m_ovf;
        logic          m_vwe;
        logic          m_rdy;
        int            pops;

        // Three queued writes then drain in order; then latency/no-bypass streaming.
        vecs[0]  = '{1'b1, AW'(12'h010), 8'hA1, 1'b0, 1'b0, AW'(0),        8'h00, 1'b1, 5'd1, 1'b0};
        vecs[1]  = '{1'b1, AW'(12'h011), 8'hB2, 1'b0, 1'b0, AW'(0),        8'h00, 1'b1, 5'd2, 1'b0};
        vecs[2]  = '{1'b1, AW'(12'h010), 8'hC3, 1'b0, 1'b0, AW'(0),        8'h00, 1'b1, 5'd3, 1'b0};
        vecs[3]  = '{1'b0, AW'(0),       8'h00, 1'b0, 1'b0, AW'(0),        8'h00, 1'b1, 5'd3, 1'b0};
        vecs[4]  = '{1'b0, AW'(0),       8'h00, 1'b1, 1'b1, AW'(12'h010),  8'hA1, 1'b1, 5'd2, 1'b0};
        vecs[5]  = '{1'b0, AW'(0),       8'h00, 1'b1, 1'b1, AW'(12'h011),  8'hB2, 1'b1, 5'd1, 1'b0};
        vecs[6]  = '{1'b0, AW'(0),       8'h00, 1'b1, 1'b1, AW'(12'h010),  8'hC3, 1'b1, 5'd0, 1'b0};
        vecs[7]  = '{1'b0, AW'(0),       8'h00, 1'b1, 1'b0, AW'(0),        8'h00, 1'b1, 5'd0, 1'b0};
        vecs[8]  = '{1'b1, AW'(12'h123), 8'h55, 1'b1, 1'b0, AW'(0),        8'h00, 1'b1, 5'd1, 1'b0};
        vecs[9]  = '{1'b1, AW'(12'h124), 8'h66, 1'b1, 1'b1, AW'(12'h123),  8'h55, 1'b1, 5'd1, 1'b0};
        vecs[10] = '{1'b1, AW'(12'h125), 8'h77, 1'b1, 1'b1, AW'(12'h124),  8'h66, 1'b1, 5'd1, 1'b0};
        vecs[11] = '{1'b0, AW'(0),       8'h00, 1'b1, 1'b1, AW'(12'h125),  8'h77, 1'b1, 5'd0, 1'b0};
        vecs[12] = '{1'b0, AW'(0),       8'h00, 1'b1, 1'b0, AW'(0),        8'h00, 1'b1, 5'd0, 1'b0};

        idle_inputs();
        writable = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        chk("reset level", 32'(level), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset cpu_ready", 32'(bus.cpu_ready), 32'd1);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset vram_we", 32'(vram_we), 32'd0);
        rst = 1'b1;
        writable = 1'b0;

        for (int i = 0; i < 13; i++) begin
            bus.cpu_we      = vecs[i].we;
            bus.cpu_address = vecs[i].addr;
            bus.cpu_data    = vecs[i].data;
            writable        = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d vram_we", i), 32'(vram_we), 32'(vecs[i].e_vwe));
            if (vecs[i].e_vwe) begin
                chk($sformatf("vec%0d vram_address", i), 32'(vram_address), 32'(vecs[i].e_addr));
                chk($sformatf("vec%0d vram_data", i), 32'(vram_data), 32'(vecs[i].e_data));
            end
            chk($sformatf("vec%0d cpu_ready", i), 32'(bus.cpu_ready), 32'(vecs[i].e_ready));
            tick();
            chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_level == 5'd0));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end
        idle_inputs();

        // Fill to DEPTH, drop the 17th, overflow clear and set-wins-over-clear.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk($sformatf("fill ready[%0d]", i), 32'(bus.cpu_ready), 32'd1);
            push_n(1, AW'(i), 8'h40 + 8'(i));
            chk($sformatf("fill level[%0d]", i), 32'(level), 32'(i + 1));
        end
        chk("full cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("full no overflow yet", 32'(overflow), 32'd0);
        push_n(1, AW'(12'h2FF), 8'hFF);
        chk("drop level", 32'(level), 32'd16);
        chk("drop overflow", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("overflow_clr", 32'(overflow), 32'd0);
        overflow_clr = 1'b1;
        push_n(1, AW'(12'h2FE), 8'hFE);
        overflow_clr = 1'b0;
        chk("drop beats clr", 32'(overflow), 32'd1);
        chk("drop beats clr level", 32'(level), 32'd16);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("overflow_clr again", 32'(overflow), 32'd0);
        drain_check("full-drain", DEPTH, AW'(0), 8'h40);

        // Window open for exactly 4 cycles with 10 queued.
        do_reset();
        push_n(10, AW'(12'h100), 8'h10);
        nwr = 0;
        writable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (vram_we) nwr++;
            tick();
        end
        writable = 1'b0;
        #1;
        chk("no write after window closes", 32'(vram_we), 32'd0);
        for (int c = 0; c < 3; c++) begin
            if (vram_we) nwr++;
            tick();
        end
        chk("window write count", 32'(nwr), 32'd4);
        chk("window level", 32'(level), 32'd6);
        drain_check("window-rest", 6, AW'(12'h104), 8'h14);

        // Full with simultaneous pop: push still refused.
        do_reset();
        push_n(DEPTH, AW'(12'h200), 8'h50);
        bus.cpu_we      = 1'b1;
        bus.cpu_address = AW'(12'h3FF);
        bus.cpu_data    = 8'hEE;
        writable        = 1'b1;
        #1;
        chk("full+pop cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("full+pop vram_we", 32'(vram_we), 32'd1);
        chk("full+pop head data", 32'(vram_data), 32'h50);
        tick();
        bus.cpu_we = 1'b0;
        writable   = 1'b0;
        chk("full+pop level", 32'(level), 32'd15);
        chk("full+pop overflow", 32'(overflow), 32'd1);
        drain_check("full+pop-rest", 15, AW'(12'h201), 8'h51);

        // Reset mid-drain discards entries; writes during reset ignored.
        do_reset();
        push_n(8, AW'(12'h300), 8'h80);
        writable = 1'b1;
        tick();
        tick();
        tick();
        chk("pre-reset level", 32'(level), 32'd5);
        rst             = 1'b0;
        bus.cpu_we      = 1'b1;
        bus.cpu_address = AW'(12'h077);
        bus.cpu_data    = 8'h77;
        tick();
        bus.cpu_we = 1'b0;
        chk("mid reset level", 32'(level), 32'd0);
        chk("mid reset vram_we", 32'(vram_we), 32'd0);
        chk("mid reset empty", 32'(empty), 32'd1);
        chk("mid reset cpu_ready", 32'(bus.cpu_ready), 32'd1);
        rst = 1'b1;
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (vram_we) nwr++;
            tick();
        end
        chk("writes after reset release", 32'(nwr), 32'd0);
        chk("level after reset release", 32'(level), 32'd0);
        writable = 1'b0;

        // Long mixed traffic against a queue model; wraps pointers many times.
        do_reset();
        m_ovf = 1'b0;
        pops  = 0;
        for (int c = 0; c < 300; c++) begin
            bus.cpu_we      = ($urandom_range(0, 3) != 0);
            bus.cpu_address = AW'($urandom);
            bus.cpu_data    = 8'($urandom);
            writable        = (c % 40 < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
            m_vwe = writable && (q.size() > 0);
            m_rdy = (q.size() < DEPTH);
            #1;
            chk($sformatf("sb vram_we c%0d", c), 32'(vram_we), 32'(m_vwe));
            chk($sformatf("sb cpu_ready c%0d", c), 32'(bus.cpu_ready), 32'(m_rdy));
            if (m_vwe) begin
                chk($sformatf("sb entry c%0d", c), 32'({vram_address, vram_data}), 32'(q[0]));
            end
            tick();
            if (m_vwe) begin
                void'(q.pop_front());
                pops++;
            end
            if (bus.cpu_we && m_rdy) q.push_back({bus.cpu_address, bus.cpu_data});
            if (bus.cpu_we && !m_rdy) m_ovf = 1'b1;
            chk($sformatf("sb level c%0d", c), 32'(level), 32'(q.size()));
            chk($sformatf("sb overflow c%0d", c), 32'(overflow), 32'(m_ovf));
        end
        chk("sb pops beyond 3*DEPTH", 32'(pops > 3 * DEPTH), 32'd1);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
